// File: rtl/sdram_arb_pkg.sv
// Shared types and sizes for the three-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ID_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        REFRESH
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_refresh_timer.sv
// Free-running refresh interval counter; raises a non-queuing pending flag on each wrap.
module sdram_arb_refresh_timer #(
    parameter int unsigned REFRESH_INTERVAL = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pending
);

    localparam int unsigned CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CNT_W-1:0] cnt;

    // A wrap in the same cycle as a clear wins, so a fresh refresh is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (cnt == CNT_W'(REFRESH_INTERVAL - 1)) begin
            cnt     <= '0;
            pending <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM arbiter: fixed priority for port 0, round-robin between ports 1 and 2,
// refresh injection between transactions and a per-access timeout.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W           = 25,
    parameter int unsigned REFRESH_INTERVAL = 250,
    parameter int unsigned TIMEOUT          = 63
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   din,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [DATA_W-1:0]             dout,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_din,
    input  logic [DATA_W-1:0]             mem_dout,
    input  logic                          mem_ready,
    output logic                          mem_refresh,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    arb_state_e           state, state_n;
    logic [TO_W-1:0]      tcnt, tcnt_n;
    logic                 rr_favor2, rr_favor2_n;
    logic [ID_W-1:0]      grant_n;
    logic [DATA_W-1:0]    dout_n;
    logic                 terr_n;
    logic                 latch_en;
    logic                 refresh_start;
    logic                 refresh_pending;
    logic                 to_hit;
    logic                 we_sel;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    din_sel;
    logic [NUM_PORTS-1:0] ack_n;

    sdram_arb_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (refresh_start),
        .pending (refresh_pending)
    );

    // Next-state, grant selection and registered-output precomputation.
    always_comb begin
        state_n       = state;
        tcnt_n        = tcnt;
        rr_favor2_n   = rr_favor2;
        grant_n       = grant_id;
        dout_n        = dout;
        terr_n        = timeout_err;
        latch_en      = 1'b0;
        refresh_start = 1'b0;
        to_hit        = (tcnt == TO_W'(TIMEOUT - 1));
        we_sel        = 1'b0;
        addr_sel      = '0;
        din_sel       = '0;
        ack_n         = '0;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (refresh_pending) begin
                    refresh_start = 1'b1;
                    state_n       = REFRESH;
                end else if (req[0]) begin
                    grant_n  = ID_W'(0);
                    latch_en = 1'b1;
                    state_n  = ISSUE;
                end else if (req[1] && (!req[2] || !rr_favor2)) begin
                    grant_n     = ID_W'(1);
                    rr_favor2_n = 1'b1;
                    latch_en    = 1'b1;
                    state_n     = ISSUE;
                end else if (req[2]) begin
                    grant_n     = ID_W'(2);
                    rr_favor2_n = 1'b0;
                    latch_en    = 1'b1;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    dout_n  = mem_dout;
                    state_n = ACK;
                end else if (to_hit) begin
                    terr_n  = 1'b1;
                    dout_n  = 8'hFF;
                    state_n = ACK;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            REFRESH: begin
                if (mem_ready) begin
                    state_n = IDLE;
                end else if (to_hit) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant_n == ID_W'(i)) begin
                we_sel   = we[i];
                addr_sel = addr[i*ADDR_W +: ADDR_W];
                din_sel  = din[i*DATA_W +: DATA_W];
            end
            ack_n[i] = (state_n == ACK) && (grant_n == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            rr_favor2   <= 1'b0;
            grant_id    <= '0;
            dout        <= '0;
            timeout_err <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_refresh <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            rr_favor2   <= rr_favor2_n;
            grant_id    <= grant_n;
            dout        <= dout_n;
            timeout_err <= terr_n;
            ack         <= ack_n;
            busy        <= (state_n != IDLE);
            mem_req     <= (state_n == ISSUE);
            mem_refresh <= refresh_start;
            if (latch_en) begin
                mem_we   <= we_sel;
                mem_addr <= addr_sel;
                mem_din  <= din_sel;
            end
        end
    end

endmodule
